// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types for the sequential ALU
// Purpose: opcode map (uc_t), FSM state encoding (state_t) and the
//          first illegal opcode value, used by alu_seq and its divider.
// Ports:   none (package).
package alu_pkg;

  typedef enum logic [3:0] {
    UC_ADD = 4'd0,
    UC_SUB = 4'd1,
    UC_MUL = 4'd2,
    UC_DIV = 4'd3,
    UC_MOD = 4'd4,
    UC_AND = 4'd5,
    UC_OR  = 4'd6,
    UC_XOR = 4'd7,
    UC_SHL = 4'd8,
    UC_SHR = 4'd9,
    UC_SRA = 4'd10
  } uc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Every opcode at or above this value is illegal.
  localparam logic [3:0] UC_ILL_MIN = 4'b1011;

endpackage

// File: rtl/alu_seq_divider.sv
// rtl/alu_seq_divider.sv - iterative unsigned restoring divider
// Purpose: WIDTH-step restoring division. The first step is taken on the
//          start edge, so done is visible WIDTH-1 cycles after start.
// Ports:   clk, rst_n          clock, async active-low reset
//          start               load operands and take the first step
//          dividend, divisor   operands (divisor must be nonzero)
//          busy                iterations still in progress
//          done                quotient/remainder valid (held until next start)
//          quotient, remainder results
module alu_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;

  // One restoring step: shift the next dividend bit (quotient MSB) into the
  // partial remainder, subtract, and keep the difference only if it did not
  // borrow. The partial remainder stays below the divisor, so the trial
  // difference fits in WIDTH bits whenever bit WIDTH is clear.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;
    sh    = {r, q[WIDTH-1]};
    trial = sh - {1'b0, d};
    if (!trial[WIDTH]) return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    else               return {sh[WIDTH-1:0],    q[WIDTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsr       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      {remainder, quotient} <= div_step('0, dividend, divisor);
      dsr  <= divisor;
      cnt  <= CW'(1);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      {remainder, quotient} <= div_step(remainder, quotient, dsr);
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshakes
// Purpose: captures a, b, uc on accept; single-cycle ops finish in one
//          cycle, MUL (shift-add) and DIV/MOD (restoring) in WIDTH+1.
//          Result and flags are registered and held until out_ready.
// Ports:   clk, rst_n            clock, async active-low reset
//          in_valid, in_ready    operand handshake (ready only in IDLE)
//          a, b, uc              operands / shift amount, opcode
//          out_valid, out_ready  result handshake
//          result, n, z, c, v    result and arithmetic flags
//          dz, ill               divide-by-zero, illegal opcode
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       uc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             dz,
  output logic             ill
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] W_VAL = (WIDTH + 1)'(WIDTH);

  state_t             state;
  logic [3:0]         op;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  logic                    accept, is_div, multi, amt_big, last;
  logic [WIDTH:0]          add_w, sub_w, shl_w, shr_w;
  logic signed [WIDTH:0]   sra_w;
  logic [WIDTH-1:0]        s_res, m_res;
  logic                    s_c, s_v, s_dz, s_ill, m_c;
  logic                    div_start, div_busy, div_done;
  logic [WIDTH-1:0]        div_q, div_r;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign is_div    = (uc == UC_DIV) || (uc == UC_MOD);
  // Division by zero is resolved in one cycle and never starts the divider.
  assign multi     = (uc == UC_MUL) || (is_div && (b != '0));
  assign div_start = accept && is_div && (b != '0);
  assign amt_big   = ({1'b0, b} >= W_VAL);

  // Shift-add step on {high, low}: low starts as the multiplier and drains
  // out of the bottom while partial sums enter at the top.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [2*WIDTH-1:0] p,
    input logic [WIDTH-1:0]   m
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  // Single-cycle results, computed straight from the inputs at accept.
  // The extra bit on each shift catches the last bit shifted out.
  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    shl_w = {1'b0, a} << b;
    shr_w = {a, 1'b0} >> b;
    sra_w = $signed({a, 1'b0}) >>> b;
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_dz  = 1'b0;
    s_ill = 1'b0;
    case (uc)
      UC_ADD: begin
        s_res = add_w[WIDTH-1:0];
        s_c   = add_w[WIDTH];
        s_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      UC_SUB: begin
        s_res = sub_w[WIDTH-1:0];
        s_c   = !sub_w[WIDTH];
        s_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      UC_MUL: s_res = '0;
      UC_DIV, UC_MOD: s_dz = (b == '0);
      UC_AND: s_res = a & b;
      UC_OR:  s_res = a | b;
      UC_XOR: s_res = a ^ b;
      UC_SHL: if (!amt_big) {s_c, s_res} = shl_w;
      UC_SHR: if (!amt_big) {s_res, s_c} = shr_w;
      UC_SRA: begin
        if (amt_big) s_res = {WIDTH{a[WIDTH-1]}};
        else         {s_res, s_c} = sra_w;
      end
      default: s_ill = (uc >= UC_ILL_MIN);
    endcase
  end

  // Multi-cycle results, valid on the final BUSY cycle.
  always_comb begin
    if (op == UC_MUL)      m_res = prod[WIDTH-1:0];
    else if (op == UC_DIV) m_res = div_q;
    else                   m_res = div_r;
    m_c  = (op == UC_MUL) && (prod[2*WIDTH-1:WIDTH] != '0);
    last = (op == UC_MUL) ? (cnt == LAST) : (div_done && !div_busy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op     <= UC_ADD;
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
      result <= '0;
      n      <= 1'b0;
      z      <= 1'b0;
      c      <= 1'b0;
      v      <= 1'b0;
      dz     <= 1'b0;
      ill    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op    <= uc;
            mcand <= a;
            cnt   <= '0;
            // First multiply step is taken here so BUSY lasts WIDTH cycles.
            prod  <= mul_step({{WIDTH{1'b0}}, b}, a);
            if (multi) begin
              state <= ST_BUSY;
            end else begin
              state  <= ST_DONE;
              result <= s_res;
              n      <= s_res[WIDTH-1];
              z      <= (s_res == '0);
              c      <= s_c;
              v      <= s_v;
              dz     <= s_dz;
              ill    <= s_ill;
            end
          end
        end
        ST_BUSY: begin
          if (last) begin
            state  <= ST_DONE;
            result <= m_res;
            n      <= m_res[WIDTH-1];
            z      <= (m_res == '0);
            c      <= m_c;
            v      <= 1'b0;
            dz     <= 1'b0;
            ill    <= 1'b0;
          end else begin
            cnt  <= cnt + CW'(1);
            prod <= mul_step(prod, mcand);
          end
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=4
// Purpose: directed and random operations checked against an arithmetic
//          reference model, including latency, backpressure and reset abort.
// Ports:   none (top-level bench).
module tb_alu_seq;

  localparam int W    = 4;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   uc;
  logic         n, z, c, v, dz, ill;
  logic [W+5:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  assign obs = {ill, dz, v, c, z, n, result};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .uc        (uc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .n         (n),
    .z         (z),
    .c         (c),
    .v         (v),
    .dz        (dz),
    .ill       (ill)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ill, dz, v, c, z, n, result} from plain integer arithmetic.
  function automatic logic [W+5:0] model(input int ai, input int bi, input int op);
    int r, cc, vv, dzz, il, sa, sb, t;
    r = 0; cc = 0; vv = 0; dzz = 0; il = 0;
    sa = (ai >= HALF) ? ai - FULL : ai;
    sb = (bi >= HALF) ? bi - FULL : bi;
    case (op)
      0: begin t = ai + bi; r = t % FULL; cc = (t >= FULL);
               t = sa + sb; vv = (t < -HALF || t >= HALF); end
      1: begin r = (ai - bi + FULL) % FULL; cc = (ai >= bi);
               t = sa - sb; vv = (t < -HALF || t >= HALF); end
      2: begin t = ai * bi; r = t % FULL; cc = (t >= FULL); end
      3: if (bi == 0) dzz = 1; else r = ai / bi;
      4: if (bi == 0) dzz = 1; else r = ai % bi;
      5: r = ai & bi;
      6: r = ai | bi;
      7: r = ai ^ bi;
      8: if (bi == 0) r = ai;
         else if (bi < W) begin r = (ai << bi) % FULL; cc = (ai >> (W - bi)) & 1; end
      9: if (bi < W) begin r = ai >> bi; if (bi > 0) cc = (ai >> (bi - 1)) & 1; end
      10: if (bi >= W) r = (sa < 0) ? FULL - 1 : 0;
          else begin r = (sa >>> bi) & (FULL - 1); if (bi > 0) cc = (ai >> (bi - 1)) & 1; end
      default: il = 1;
    endcase
    return {il[0], dzz[0], vv[0], cc[0], (r == 0), r[W-1], r[W-1:0]};
  endfunction

  task automatic do_op(input int ai, input int bi, input int op, input int hold);
    logic [W+5:0] exp, got0;
    int lat, exp_lat;
    bit busy_ok, stable_ok;
    exp     = model(ai, bi, op);
    exp_lat = (op == 2 || ((op == 3 || op == 4) && bi != 0)) ? W + 1 : 1;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = W'(ai); b = W'(bi); uc = 4'(op); in_valid = 1'b1;
    @(posedge clk); #1;
    // Junk on the inputs while busy must be ignored.
    a = W'($urandom); b = W'($urandom); uc = 4'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat));
    chk($sformatf("busy_ready op%0d", op), 32'(busy_ok), 32'd1);
    chk($sformatf("out op%0d a%0d b%0d", op, ai, bi), 32'(obs), 32'(exp));
    got0 = obs; stable_ok = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (obs !== got0 || !out_valid) stable_ok = 1'b0;
    end
    if (hold > 0) chk($sformatf("hold op%0d", op), 32'(stable_ok), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; uc = '0;
    #12;
    chk("reset_outs", 32'({out_valid, obs}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 32'(in_ready), 32'd1);

    do_op(12, 2, 0, 0);
    do_op(7, 1, 0, 0);
    do_op(2, 12, 1, 0);
    do_op(12, 2, 1, 0);
    do_op(5, 4, 2, 3);
    do_op(13, 4, 3, 0);
    do_op(13, 4, 4, 0);
    do_op(2, 0, 3, 0);
    do_op(9, 0, 4, 1);
    do_op(10, 2, 8, 0);
    do_op(10, 1, 10, 0);
    do_op(10, 5, 9, 0);
    do_op(10, 4, 10, 0);
    do_op(15, 0, 8, 0);
    do_op(3, 7, 12, 2);

    // Reset in the middle of a multiply.
    @(negedge clk);
    a = 4'd5; b = 4'd4; uc = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mul_busy", 32'({in_ready, out_valid}), 32'd0);
    rst_n = 1'b0; #1;
    chk("abort_outs", 32'({out_valid, obs}), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (W + 2) @(posedge clk);
    #1;
    chk("abort_no_delivery", 32'({in_ready, out_valid}), 32'b10);
    do_op(3, 4, 0, 0);

    for (int i = 0; i < 300; i++)
      do_op($urandom_range(0, FULL - 1), $urandom_range(0, FULL - 1),
            $urandom_range(0, 15), $urandom_range(0, 3));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
